// File: rtl/clk_pkg.sv
// Shared definitions for the clock/reset unit: the ratio monitor state
// encoding and the ratio width shared with the programmable divider.
package clk_pkg;

   // Width of divider ratios and of the monitor's period/high counters.
   localparam int unsigned CLK_RATIO_W = 8;

   // Ratio monitor FSM states.
   typedef enum logic [1:0] {
      MON_IDLE    = 2'd0,
      MON_SEEK    = 2'd1,
      MON_MEASURE = 2'd2
   } mon_state_e;

endpackage : clk_pkg

// File: rtl/clk_sync_bit.sv
// Single-bit multi-flop synchroniser for an asynchronous input.
// Flops reset to 0; the output is the last stage of the chain.
module clk_sync_bit #(
   parameter int unsigned NUM_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [NUM_STAGES-1:0] sync_q;

   // Shift the async input through the synchroniser chain.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[NUM_STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[NUM_STAGES-1];

endmodule : clk_sync_bit

// File: rtl/clk_ratio_monitor.sv
// Divided-clock ratio monitor: measures the period and high time of
// i_mon_clk in i_ref_clk cycles, reports each measurement, declares lock
// after LOCK_CNT identical consecutive periods, and flags ratio mismatch
// against i_exp_ratio or a missing rising edge (timeout).
module clk_ratio_monitor
   import clk_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = CLK_RATIO_W,
   parameter int unsigned LOCK_CNT    = 4
) (
   input  logic             i_ref_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_mon_clk,
   input  logic [CNT_W-1:0] i_exp_ratio,
   output logic [CNT_W-1:0] o_ratio,
   output logic [CNT_W-1:0] o_high_cycles,
   output logic             o_valid,
   output logic             o_locked,
   output logic             o_mismatch,
   output logic             o_timeout
);

   localparam int unsigned     MW        = (LOCK_CNT > 2) ? $clog2(LOCK_CNT) : 1;
   localparam logic [MW-1:0]   MATCH_MAX = MW'(LOCK_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Synchronised monitored clock and its one-cycle delayed copy.
   logic mon_s;
   logic mon_s_dly_q;
   logic mon_rise;

   // FSM and measurement state.
   mon_state_e       state_q,     state_d;
   logic [CNT_W-1:0] per_cnt_q,   per_cnt_d;
   logic [CNT_W-1:0] hi_cnt_q,    hi_cnt_d;
   logic [MW-1:0]    match_cnt_q, match_cnt_d;
   logic             have_prev_q, have_prev_d;

   // Registered outputs.
   logic [CNT_W-1:0] ratio_q,     ratio_d;
   logic [CNT_W-1:0] high_q,      high_d;
   logic             valid_q,     valid_d;
   logic             locked_q,    locked_d;
   logic             mismatch_q,  mismatch_d;
   logic             timeout_q,   timeout_d;

   // Lock bookkeeping helpers for the rise cycle.
   logic             same_period;
   logic [MW-1:0]    match_next;

   clk_sync_bit #(
      .NUM_STAGES (SYNC_STAGES)
   ) u_mon_sync (
      .clk_i  (i_ref_clk),
      .rst_ni (i_rst_n),
      .d_i    (i_mon_clk),
      .q_o    (mon_s)
   );

   assign mon_rise = mon_s & ~mon_s_dly_q;

   // A measurement only counts toward lock if an earlier measurement from
   // the same SEEK->MEASURE run exists to compare against.
   assign same_period = have_prev_q && (per_cnt_q == ratio_q);
   assign match_next  = (match_cnt_q == MATCH_MAX) ? MATCH_MAX : (match_cnt_q + MW'(1));

   // State register, edge-detect delay flop and output registers.
   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mon_s_dly_q <= 1'b0;
         state_q     <= MON_IDLE;
         per_cnt_q   <= '0;
         hi_cnt_q    <= '0;
         match_cnt_q <= '0;
         have_prev_q <= 1'b0;
         ratio_q     <= '0;
         high_q      <= '0;
         valid_q     <= 1'b0;
         locked_q    <= 1'b0;
         mismatch_q  <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         mon_s_dly_q <= mon_s;
         state_q     <= state_d;
         per_cnt_q   <= per_cnt_d;
         hi_cnt_q    <= hi_cnt_d;
         match_cnt_q <= match_cnt_d;
         have_prev_q <= have_prev_d;
         ratio_q     <= ratio_d;
         high_q      <= high_d;
         valid_q     <= valid_d;
         locked_q    <= locked_d;
         mismatch_q  <= mismatch_d;
         timeout_q   <= timeout_d;
      end
   end

   // Next-state, counter, lock and output logic.
   always_comb begin
      state_d     = state_q;
      per_cnt_d   = per_cnt_q;
      hi_cnt_d    = hi_cnt_q;
      match_cnt_d = match_cnt_q;
      have_prev_d = have_prev_q;
      ratio_d     = ratio_q;
      high_d      = high_q;
      valid_d     = 1'b0;
      locked_d    = locked_q;
      mismatch_d  = mismatch_q;
      timeout_d   = timeout_q;

      if (!i_en) begin
         state_d     = MON_IDLE;
         per_cnt_d   = '0;
         hi_cnt_d    = '0;
         match_cnt_d = '0;
         have_prev_d = 1'b0;
         ratio_d     = '0;
         high_d      = '0;
         locked_d    = 1'b0;
         mismatch_d  = 1'b0;
         timeout_d   = 1'b0;
      end else begin
         unique case (state_q)
            MON_IDLE: begin
               state_d = MON_SEEK;
            end

            MON_SEEK: begin
               if (mon_rise) begin
                  state_d   = MON_MEASURE;
                  per_cnt_d = CNT_ONE;
                  hi_cnt_d  = CNT_ONE;
               end
            end

            MON_MEASURE: begin
               if (mon_rise) begin
                  ratio_d     = per_cnt_q;
                  high_d      = hi_cnt_q;
                  valid_d     = 1'b1;
                  mismatch_d  = (per_cnt_q != i_exp_ratio);
                  timeout_d   = 1'b0;
                  per_cnt_d   = CNT_ONE;
                  hi_cnt_d    = CNT_ONE;
                  have_prev_d = 1'b1;
                  if (same_period) begin
                     match_cnt_d = match_next;
                     locked_d    = (match_next == MATCH_MAX);
                  end else begin
                     match_cnt_d = '0;
                     locked_d    = 1'b0;
                  end
               end else if (per_cnt_q == '1) begin
                  // Period counter exhausted: abandon this measurement but
                  // keep the last reported ratio visible.
                  state_d     = MON_SEEK;
                  timeout_d   = 1'b1;
                  locked_d    = 1'b0;
                  match_cnt_d = '0;
                  have_prev_d = 1'b0;
               end else begin
                  per_cnt_d = per_cnt_q + CNT_ONE;
                  if (mon_s && (hi_cnt_q != '1)) begin
                     hi_cnt_d = hi_cnt_q + CNT_ONE;
                  end
               end
            end

            default: begin
               state_d = MON_IDLE;
            end
         endcase
      end
   end

   assign o_ratio       = ratio_q;
   assign o_high_cycles = high_q;
   assign o_valid       = valid_q;
   assign o_locked      = locked_q;
   assign o_mismatch    = mismatch_q;
   assign o_timeout     = timeout_q;

endmodule : clk_ratio_monitor

// File: tb/tb_clk_ratio_monitor.sv
// Directed self-checking bench for clk_ratio_monitor. A behavioural divider
// drives i_mon_clk on the falling ref edge; outputs are sampled on the
// falling edge, away from the active posedge.
module tb_clk_ratio_monitor;

   logic       i_ref_clk = 1'b0;
   logic       i_rst_n   = 1'b0;
   logic       i_en      = 1'b0;
   logic       i_mon_clk = 1'b0;
   logic [7:0] i_exp_ratio = '0;
   logic [7:0] o_ratio;
   logic [7:0] o_high_cycles;
   logic       o_valid;
   logic       o_locked;
   logic       o_mismatch;
   logic       o_timeout;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Divider model controls.
   int div_ratio = 4;
   bit div_run   = 1'b0;
   int cur_ratio = 4;
   int cur_hi    = 2;
   int ph        = 0;
   bit odd_tog   = 1'b0;

   clk_ratio_monitor #(
      .SYNC_STAGES (2),
      .CNT_W       (8),
      .LOCK_CNT    (4)
   ) dut (
      .i_ref_clk     (i_ref_clk),
      .i_rst_n       (i_rst_n),
      .i_en          (i_en),
      .i_mon_clk     (i_mon_clk),
      .i_exp_ratio   (i_exp_ratio),
      .o_ratio       (o_ratio),
      .o_high_cycles (o_high_cycles),
      .o_valid       (o_valid),
      .o_locked      (o_locked),
      .o_mismatch    (o_mismatch),
      .o_timeout     (o_timeout)
   );

   always #5 i_ref_clk = ~i_ref_clk;

   always @(posedge i_ref_clk) cyc = cyc + 1;

   // Divider: new ratio taken at each period start; odd ratios alternate
   // the high time between ratio/2 and ratio/2+1.
   always @(negedge i_ref_clk) begin
      if (!div_run) begin
         i_mon_clk = 1'b0;
         ph        = 0;
         odd_tog   = 1'b0;
      end else begin
         if (ph == 0) begin
            cur_ratio = div_ratio;
            if ((cur_ratio % 2) == 1) begin
               cur_hi  = cur_ratio / 2 + int'(odd_tog);
               odd_tog = ~odd_tog;
            end else begin
               cur_hi = cur_ratio / 2;
            end
         end
         i_mon_clk = (ph < cur_hi);
         ph = (ph + 1 >= cur_ratio) ? 0 : ph + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {12'd0, o_ratio, o_high_cycles, o_valid, o_locked, o_mismatch, o_timeout};
   endfunction

   // Wait (bounded) for the next o_valid pulse; an expired bound is a failure.
   task automatic next_valid(input string tag, input int max_cyc);
      bit got;
      got = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge i_ref_clk);
         if (o_valid) begin
            got = 1'b1;
            break;
         end
      end
      check_eq(tag, 32'(got), 32'd1);
   endtask

   task automatic restart(input int ratio, input logic [7:0] exp);
      i_en    = 1'b0;
      div_run = 1'b0;
      repeat (3) @(negedge i_ref_clk);
      div_ratio   = ratio;
      i_exp_ratio = exp;
      div_run     = 1'b1;
      i_en        = 1'b1;
   endtask

   initial begin : stim
      int last_cyc;
      int hi[6];
      bit found;
      bit early;
      int nv;
      int bad;
      bit tout_seen;
      int start_cyc;

      // Reset
      repeat (3) @(negedge i_ref_clk);
      check_eq("rst_outs", all_outs(), 32'd0);
      i_rst_n = 1'b1;
      @(negedge i_ref_clk);
      check_eq("rst_idle_outs", all_outs(), 32'd0);

      // 1: ratio 4, expected 4
      restart(4, 8'd4);
      last_cyc = 0;
      for (int i = 0; i < 4; i++) begin
         next_valid("t1_valid", 40);
         check_eq("t1_ratio", 32'(o_ratio), 32'd4);
         check_eq("t1_high", 32'(o_high_cycles), 32'd2);
         check_eq("t1_mism", 32'(o_mismatch), 32'd0);
         check_eq("t1_locked", 32'(o_locked), (i == 3) ? 32'd1 : 32'd0);
         if (i > 0) check_eq("t1_spacing", 32'(cyc - last_cyc), 32'd4);
         last_cyc = cyc;
      end

      // 2: odd ratio 5
      restart(5, 8'd5);
      for (int i = 0; i < 6; i++) begin
         next_valid("t2_valid", 40);
         hi[i] = int'(o_high_cycles);
         check_eq("t2_ratio", 32'(o_ratio), 32'd5);
         check_eq("t2_hi_range", 32'((hi[i] == 2) || (hi[i] == 3)), 32'd1);
         check_eq("t2_locked", 32'(o_locked), (i >= 3) ? 32'd1 : 32'd0);
      end
      for (int i = 1; i < 6; i++) begin
         check_eq("t2_hi_pair", 32'(hi[i-1] + hi[i]), 32'd5);
      end

      // 3: lock at 4, then switch to 6 with expected still 4
      restart(4, 8'd4);
      for (int i = 0; i < 4; i++) next_valid("t3_valid4", 40);
      check_eq("t3_locked4", 32'(o_locked), 32'd1);
      div_ratio = 6;
      found = 1'b0;
      for (int i = 0; i < 4 && !found; i++) begin
         next_valid("t3_valid_chg", 40);
         if (o_ratio != 8'd4) found = 1'b1;
      end
      check_eq("t3_change_seen", 32'(found), 32'd1);
      check_eq("t3_chg_ratio", 32'(o_ratio), 32'd6);
      check_eq("t3_chg_unlock", 32'(o_locked), 32'd0);
      check_eq("t3_chg_mism", 32'(o_mismatch), 32'd1);
      for (int i = 1; i <= 3; i++) begin
         next_valid("t3_valid6", 40);
         check_eq("t3_ratio6", 32'(o_ratio), 32'd6);
         check_eq("t3_relock", 32'(o_locked), (i == 3) ? 32'd1 : 32'd0);
      end

      // 4: stop the clock right after the last rise -> timeout 255 cycles later
      div_run = 1'b0;
      early = 1'b0;
      for (int k = 1; k <= 255; k++) begin
         @(negedge i_ref_clk);
         if (k < 255 && (o_timeout || o_valid)) early = 1'b1;
      end
      check_eq("t4_no_early", 32'(early), 32'd0);
      check_eq("t4_timeout", 32'(o_timeout), 32'd1);
      check_eq("t4_ratio_held", 32'(o_ratio), 32'd6);
      check_eq("t4_mism_held", 32'(o_mismatch), 32'd1);
      check_eq("t4_unlocked", 32'(o_locked), 32'd0);
      repeat (300) @(negedge i_ref_clk);
      check_eq("t4_seek_hold", 32'(o_timeout), 32'd1);
      div_ratio   = 3;
      i_exp_ratio = 8'd3;
      div_run     = 1'b1;
      next_valid("t4_restart_valid", 40);
      check_eq("t4_tout_clr", 32'(o_timeout), 32'd0);
      check_eq("t4_ratio3", 32'(o_ratio), 32'd3);
      check_eq("t4_mism3", 32'(o_mismatch), 32'd0);
      check_eq("t4_no_false_lock", 32'(o_locked), 32'd0);

      // 5a: reset mid-measurement
      @(negedge i_ref_clk);
      i_rst_n = 1'b0;
      #1;
      check_eq("t5_rst_outs", all_outs(), 32'd0);
      repeat (2) @(negedge i_ref_clk);
      i_rst_n = 1'b1;
      start_cyc = cyc;
      next_valid("t5_rst_valid", 40);
      check_eq("t5_rst_two_rises", 32'((cyc - start_cyc) > 3), 32'd1);
      check_eq("t5_rst_ratio", 32'(o_ratio), 32'd3);
      check_eq("t5_rst_nolock", 32'(o_locked), 32'd0);

      // 5b: enable dropped mid-measurement
      @(negedge i_ref_clk);
      i_en = 1'b0;
      @(negedge i_ref_clk);
      check_eq("t5_en_outs", all_outs(), 32'd0);
      i_en = 1'b1;
      start_cyc = cyc;
      next_valid("t5_en_valid", 40);
      check_eq("t5_en_two_rises", 32'((cyc - start_cyc) > 3), 32'd1);
      check_eq("t5_en_ratio", 32'(o_ratio), 32'd3);
      check_eq("t5_en_nolock", 32'(o_locked), 32'd0);

      // 6: minimum ratio 2 for 1000 cycles
      restart(2, 8'd2);
      next_valid("t6_valid", 40);
      nv = 0;
      bad = 0;
      tout_seen = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge i_ref_clk);
         if (o_valid) begin
            nv++;
            if (o_ratio != 8'd2 || o_high_cycles != 8'd1) bad++;
         end
         if (o_timeout) tout_seen = 1'b1;
      end
      check_eq("t6_bad_meas", 32'(bad), 32'd0);
      check_eq("t6_valid_cnt", 32'(nv), 32'd500);
      check_eq("t6_no_timeout", 32'(tout_seen), 32'd0);
      check_eq("t6_locked", 32'(o_locked), 32'd1);
      check_eq("t6_mism", 32'(o_mismatch), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_clk_ratio_monitor
